// File: rtl/parking_pkg.sv
// parking_pkg: shared exit-FSM state type and default sizing for the parking slot counter
package parking_pkg;
  typedef enum logic [1:0] {X_IDLE, X_QUAL, X_HELD, X_REL} xstate_e;
  localparam int DEF_CAPACITY = 8;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_DEBOUNCE = 4;
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: qualifies a bouncing level and flags each qualified rising level once
// Ports: clk, reset (async, active-high), raw (sampled sensor level),
// pulse (combinational, high for the single cycle whose edge completes a qualified high run).
module sensor_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse
);
  localparam int RW = $clog2(DEBOUNCE + 1);
  xstate_e state_q, state_d;
  logic [RW-1:0] run_q, run_d, run_inc;
  logic last;
  assign run_inc = run_q + RW'(1);
  // The sample being taken now would complete the run.
  assign last = run_inc == RW'(DEBOUNCE);
  always_comb begin
    state_d = state_q;
    run_d = run_q;
    pulse = 1'b0;
    unique case (state_q)
      X_IDLE: begin
        if (raw) begin
          state_d = X_QUAL;
          run_d = RW'(1);
        end
      end
      X_QUAL: begin
        if (!raw) begin
          state_d = X_IDLE;
          run_d = '0;
        end else if (last) begin
          state_d = X_HELD;
          run_d = '0;
          pulse = 1'b1;
        end else begin
          run_d = run_inc;
        end
      end
      X_HELD: begin
        if (!raw) begin
          state_d = X_REL;
          run_d = RW'(1);
        end
      end
      X_REL: begin
        if (raw) begin
          state_d = X_HELD;
          run_d = '0;
        end else if (last) begin
          state_d = X_IDLE;
          run_d = '0;
        end else begin
          run_d = run_inc;
        end
      end
      default: begin
        state_d = X_IDLE;
        run_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= X_IDLE;
      run_q <= '0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/parking_slot_counter.sv
// parking_slot_counter: tracks occupied parking slots from gate grants and debounced exits
// Ports: clk, reset (async, active-high), grant_in (gate green LED level),
// exit_sensor (raw exit level), free_slots, lot_full, lot_empty, entry_allow,
// exit_evt (registered one-cycle exit pulse), err (sticky misuse flag).
module parking_slot_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             grant_in,
  input  logic             exit_sensor,
  output logic [CNT_W-1:0] free_slots,
  output logic             lot_full,
  output logic             lot_empty,
  output logic             entry_allow,
  output logic             exit_evt,
  output logic             err
);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
  logic grant_prev_q, exit_evt_q, err_q, err_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic entry, exit_fire;
  sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_exit (
    .clk(clk),
    .reset(reset),
    .raw(exit_sensor),
    .pulse(exit_fire)
  );
  assign entry = grant_in & ~grant_prev_q;
  // Coincident entry and exit cancel; a lone event at a bound is refused and flagged.
  always_comb begin
    occ_d = (entry & ~exit_fire & (occ_q != CAP)) ? occ_q + CNT_W'(1) :
            (exit_fire & ~entry & (occ_q != '0)) ? occ_q - CNT_W'(1) : occ_q;
    err_d = err_q | ((entry ^ exit_fire) & (entry ? occ_q == CAP : occ_q == '0));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_prev_q <= 1'b0;
      occ_q <= '0;
      err_q <= 1'b0;
      exit_evt_q <= 1'b0;
    end else begin
      grant_prev_q <= grant_in;
      occ_q <= occ_d;
      err_q <= err_d;
      exit_evt_q <= exit_fire;
    end
  end
  assign free_slots = CAP - occ_q;
  assign lot_full = occ_q == CAP;
  assign lot_empty = occ_q == '0;
  assign entry_allow = ~lot_full;
  assign exit_evt = exit_evt_q;
  assign err = err_q;
endmodule

// File: tb/tb_parking_slot_counter.sv
// tb_parking_slot_counter: scoreboard bench for parking_slot_counter against a behavioural occupancy model
module tb_parking_slot_counter;
  localparam int CAP = 8;
  localparam int D = 4;
  logic clk = 0, reset = 1, grant_in = 0, exit_sensor = 0;
  logic [3:0] free_slots;
  logic lot_full, lot_empty, entry_allow, exit_evt, err;
  int tests = 0, fails = 0;
  logic [8:0] exp_q[$];
  int m_occ = 0, m_run = 0;
  logic m_err = 0, m_gp = 0, m_lvl = 0;

  parking_slot_counter dut (
    .clk(clk), .reset(reset), .grant_in(grant_in), .exit_sensor(exit_sensor),
    .free_slots(free_slots), .lot_full(lot_full), .lot_empty(lot_empty),
    .entry_allow(entry_allow), .exit_evt(exit_evt), .err(err)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and predict the outputs seen after the next rising edge.
  // The exit sensor is modelled as a stable level that flips only after D consecutive
  // samples disagree with it; each flip to 1 is one car leaving.
  task automatic cyc(input logic g, input logic s, input logic r);
    logic entry, fire;
    @(negedge clk);
    grant_in = g;
    exit_sensor = s;
    reset = r;
    fire = 0;
    if (r) begin
      m_occ = 0; m_run = 0; m_err = 0; m_gp = 0; m_lvl = 0;
    end else begin
      entry = g && !m_gp;
      m_gp = g;
      if (s != m_lvl) begin
        m_run++;
        if (m_run == D) begin
          m_lvl = s;
          m_run = 0;
          fire = s;
        end
      end else m_run = 0;
      if (entry && !fire) begin
        if (m_occ < CAP) m_occ++; else m_err = 1;
      end else if (fire && !entry) begin
        if (m_occ > 0) m_occ--; else m_err = 1;
      end
    end
    exp_q.push_back({4'(CAP - m_occ), m_occ == CAP, m_occ == 0, m_occ != CAP, fire, m_err});
  endtask

  task automatic grants(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
    end
  endtask

  task automatic exitq();
    repeat (D) cyc(0, 1, 0);
    repeat (D + 1) cyc(0, 0, 0);
  endtask

  task automatic do_reset();
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0);
  endtask

  // Coincident grant edge and exit qualification on the same clock edge.
  task automatic coincide();
    repeat (D - 1) cyc(0, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 0);
    repeat (D + 1) cyc(0, 0, 0);
  endtask

  initial begin
    logic [8:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = {free_slots, lot_full, lot_empty, entry_allow, exit_evt, err};
        tests++;
        if (got !== e) begin
          fails++;
          $display("FAIL outputs t=%0t got free=%0d full=%b empty=%b allow=%b evt=%b err=%b, want free=%0d full=%b empty=%b allow=%b evt=%b err=%b",
                   $time, got[8:5], got[4], got[3], got[2], got[1], got[0],
                   e[8:5], e[4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic s_cur;
    do_reset();
    grants(3);
    cyc(0, 1, 0); cyc(0, 1, 0); cyc(0, 1, 0);
    cyc(0, 0, 0);
    exitq();
    do_reset();
    grants(8);
    grants(1);
    coincide();
    do_reset();
    coincide();
    exitq();
    grants(1);
    do_reset();
    grants(4);
    cyc(0, 1, 0); cyc(0, 1, 0);
    cyc(0, 1, 1); cyc(0, 1, 1);
    cyc(0, 0, 0);
    exitq();
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    s_cur = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) s_cur = ~s_cur;
      cyc($urandom_range(0, 6) == 0, s_cur, $urandom_range(0, 299) == 0);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
